// File: rtl/icache_fill_ctrl.sv
// Instruction-cache fill controller.
// On a stage-2 miss it picks a round-robin victim way, requests the aligned
// line from memory, streams the returned beats into the victim data bank,
// forwards the critical (missed) word to fetch and writes the tag bank on the
// final beat.
module icache_fill_ctrl #(
  parameter int WAYS        = 2,
  parameter int LINE_ADDR_W = 6,
  parameter int SUB_LINE_W  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_req,
  input  logic [31:0]                       miss_addr,
  output logic                              fill_busy,
  output logic                              mem_req,
  output logic [31:0]                       mem_addr,
  input  logic                              mem_ack,
  input  logic                              mem_rvalid,
  input  logic [31:0]                       mem_rdata,
  output logic [WAYS-1:0]                   data_wen,
  output logic [LINE_ADDR_W+SUB_LINE_W-1:0] data_waddr,
  output logic [31:0]                       data_wdata,
  output logic                              tag_update,
  output logic [WAYS-1:0]                   tag_update_way,
  output logic                              fwd_valid,
  output logic [31:0]                       fwd_data,
  output logic                              fill_done
);

  localparam int PTR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_LO = SUB_LINE_W + 2;
  localparam logic [SUB_LINE_W-1:0] LAST_CNT = {SUB_LINE_W{1'b1}};
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(WAYS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [LINE_ADDR_W-1:0]  line_r;
  logic [SUB_LINE_W-1:0]   off_r;
  logic [SUB_LINE_W-1:0]   cnt_r;
  logic [WAYS-1:0]         victim_r;
  logic [PTR_W-1:0]        rr_ptr_r;
  logic                    mem_req_r;
  logic [31:0]             mem_addr_r;
  logic                    beat_s;

  // Byte-lane bits of the miss address never matter for a word-granular fill.
  logic unused_s;
  assign unused_s = ^miss_addr[1:0];

  // One-hot encode a way index.
  function automatic logic [WAYS-1:0] way_onehot(input logic [PTR_W-1:0] idx);
    logic [WAYS-1:0] oh;
    oh = {WAYS{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      if (idx == PTR_W'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  assign beat_s = (state_r == ST_FILL) && mem_rvalid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_req) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_FILL: begin
        if (mem_rvalid && (cnt_r == LAST_CNT)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Latch the miss context, drive the memory request and track fill progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_r     <= {LINE_ADDR_W{1'b0}};
      off_r      <= {SUB_LINE_W{1'b0}};
      cnt_r      <= {SUB_LINE_W{1'b0}};
      victim_r   <= {WAYS{1'b0}};
      rr_ptr_r   <= {PTR_W{1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_req) begin
            line_r     <= miss_addr[LINE_LO +: LINE_ADDR_W];
            off_r      <= miss_addr[2 +: SUB_LINE_W];
            victim_r   <= way_onehot(rr_ptr_r);
            cnt_r      <= {SUB_LINE_W{1'b0}};
            mem_req_r  <= 1'b1;
            mem_addr_r <= {miss_addr[31:LINE_LO], {LINE_LO{1'b0}}};
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req_r <= 1'b0;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            cnt_r <= cnt_r + {{(SUB_LINE_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (rr_ptr_r == LAST_PTR) begin
            rr_ptr_r <= {PTR_W{1'b0}};
          end else begin
            rr_ptr_r <= rr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Per-beat bank writes, critical-word forward and final tag write.
  always_comb begin
    data_wen       = {WAYS{1'b0}};
    tag_update     = 1'b0;
    tag_update_way = {WAYS{1'b0}};
    fwd_valid      = 1'b0;
    fwd_data       = 32'h0000_0000;
    if (beat_s) begin
      data_wen = victim_r;
      if (cnt_r == off_r) begin
        fwd_valid = 1'b1;
        fwd_data  = mem_rdata;
      end else begin
        fwd_valid = 1'b0;
        fwd_data  = 32'h0000_0000;
      end
      if (cnt_r == LAST_CNT) begin
        tag_update     = 1'b1;
        tag_update_way = victim_r;
      end else begin
        tag_update     = 1'b0;
        tag_update_way = {WAYS{1'b0}};
      end
    end else begin
      data_wen = {WAYS{1'b0}};
    end
  end

  assign data_waddr = {line_r, cnt_r};
  assign data_wdata = mem_rdata;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign fill_busy  = (state_r != ST_IDLE);
  assign fill_done  = (state_r == ST_DONE);

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed testbench for icache_fill_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        fill_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  data_wen;
  logic [7:0]  data_waddr;
  logic [31:0] data_wdata;
  logic        tag_update;
  logic [1:0]  tag_update_way;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        fill_done;

  int err_cnt = 0;
  int chk_cnt = 0;

  icache_fill_ctrl #(.WAYS(2), .LINE_ADDR_W(6), .SUB_LINE_W(2)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_busy(fill_busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .data_wen(data_wen), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .tag_update(tag_update), .tag_update_way(tag_update_way),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".busy"},     {31'd0, fill_busy},  32'd0);
    check_eq({tag, ".mem_req"},  {31'd0, mem_req},    32'd0);
    check_eq({tag, ".wen"},      {30'd0, data_wen},   32'd0);
    check_eq({tag, ".tag_upd"},  {31'd0, tag_update}, 32'd0);
    check_eq({tag, ".fwd"},      {31'd0, fwd_valid},  32'd0);
    check_eq({tag, ".done"},     {31'd0, fill_done},  32'd0);
  endtask

  // Raise a miss, wait ack_dly request cycles, then ack; returns in FILL.
  // noise=1 pulses mem_rvalid in IDLE and REQ, which must be ignored.
  task automatic start_fill(input logic [31:0] addr, input int ack_dly, input bit noise);
    if (noise) begin
      mem_rvalid = 1'b1;
      @(negedge clk);
      check_eq("idle_rvalid.wen", {30'd0, data_wen}, 32'd0);
      tick();
      mem_rvalid = 1'b0;
      @(negedge clk);
      check_eq("idle_rvalid.busy", {31'd0, fill_busy}, 32'd0);
      tick();
    end
    miss_req  = 1'b1;
    miss_addr = addr;
    tick();
    for (int i = 0; i < ack_dly; i++) begin
      mem_rvalid = noise;
      @(negedge clk);
      check_eq("req.mem_req",  {31'd0, mem_req}, 32'd1);
      check_eq("req.mem_addr", mem_addr, {addr[31:4], 4'h0});
      check_eq("req.wen",      {30'd0, data_wen}, 32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    mem_ack    = 1'b1;
    @(negedge clk);
    check_eq("ack.mem_req",  {31'd0, mem_req}, 32'd1);
    check_eq("ack.mem_addr", mem_addr, {addr[31:4], 4'h0});
    tick();
    mem_ack = 1'b0;
  endtask

  // Deliver one beat after `gap` idle cycles; noise=1 holds mem_ack during the gap.
  task automatic beat(input logic [31:0] addr, input int b, input logic [1:0] way,
                      input int gap, input bit noise);
    logic [31:0] d;
    logic [7:0]  wa;
    logic [1:0]  off;
    off = addr[3:2];
    wa  = {addr[9:4], 2'(b)};
    d   = 32'hD000_0000 + addr + 32'(b);
    for (int g = 0; g < gap; g++) begin
      mem_ack = noise;
      @(negedge clk);
      check_eq("gap.wen",     {30'd0, data_wen},   32'd0);
      check_eq("gap.tag_upd", {31'd0, tag_update}, 32'd0);
      check_eq("gap.mem_req", {31'd0, mem_req},    32'd0);
      tick();
    end
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    @(negedge clk);
    check_eq($sformatf("beat%0d.wen", b),   {30'd0, data_wen}, {30'd0, way});
    check_eq($sformatf("beat%0d.waddr", b), {24'd0, data_waddr}, {24'd0, wa});
    check_eq($sformatf("beat%0d.wdata", b), data_wdata, d);
    check_eq($sformatf("beat%0d.fwd", b),   {31'd0, fwd_valid}, {31'd0, (2'(b) == off)});
    if (2'(b) == off) begin
      check_eq($sformatf("beat%0d.fwd_data", b), fwd_data, d);
    end else begin
      check_eq($sformatf("beat%0d.fwd_data0", b), fwd_data, 32'd0);
    end
    check_eq($sformatf("beat%0d.tag_upd", b), {31'd0, tag_update}, {31'd0, (b == 3)});
    check_eq($sformatf("beat%0d.tag_way", b), {30'd0, tag_update_way},
             (b == 3) ? {30'd0, way} : 32'd0);
    check_eq($sformatf("beat%0d.done", b), {31'd0, fill_done}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic finish_fill();
    @(negedge clk);
    check_eq("done.pulse", {31'd0, fill_done}, 32'd1);
    check_eq("done.busy",  {31'd0, fill_busy}, 32'd1);
    check_eq("done.wen",   {30'd0, data_wen},  32'd0);
    miss_req = 1'b0;
    tick();
    @(negedge clk);
    check_eq("after.done", {31'd0, fill_done}, 32'd0);
    check_eq("after.busy", {31'd0, fill_busy}, 32'd0);
    tick();
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [1:0] way, input int ack_dly,
                          input int g0, input int g1, input int g2, input int g3,
                          input bit noise);
    start_fill(addr, ack_dly, noise);
    beat(addr, 0, way, g0, noise);
    beat(addr, 1, way, g1, noise);
    beat(addr, 2, way, g2, noise);
    beat(addr, 3, way, g3, noise);
    finish_fill();
  endtask

  initial begin
    rst        = 1'b0;
    miss_req   = 1'b0;
    miss_addr  = 32'h0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #12;
    check_idle_outputs("reset");
    check_eq("reset.mem_addr", mem_addr, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic fill: line 0x23, offset 1 -> writes 0x8C..0x8F on way0, forward on beat 1.
    run_fill(32'h0000_1234, 2'b01, 3, 0, 0, 0, 0, 1'b0);
    // Round-robin: way1, then wrap to way0.
    run_fill(32'h0000_0040, 2'b10, 0, 0, 0, 0, 0, 1'b0);
    run_fill(32'h0000_3F88, 2'b01, 1, 0, 0, 0, 0, 1'b0);
    // Beat gaps of 0, 2 and 5 cycles.
    run_fill(32'h1234_5670, 2'b10, 0, 0, 2, 5, 0, 1'b0);
    // Offset 3: forward coincides with the tag write.
    run_fill(32'h0000_2A5C, 2'b01, 2, 0, 1, 0, 0, 1'b0);
    // Stray rvalid in IDLE/REQ, stray ack in FILL gaps.
    run_fill(32'h0000_0104, 2'b10, 2, 1, 2, 1, 3, 1'b1);
    // Move the pointer to way1 before the reset test.
    run_fill(32'h0000_0008, 2'b01, 0, 0, 0, 0, 0, 1'b0);

    // Asynchronous reset after the third beat of a way1 fill.
    start_fill(32'h0000_0500, 0, 1'b0);
    beat(32'h0000_0500, 0, 2'b10, 0, 1'b0);
    beat(32'h0000_0500, 1, 2'b10, 0, 1'b0);
    beat(32'h0000_0500, 2, 2'b10, 0, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_0003;
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check_eq("async_rst.waddr", {24'd0, data_waddr}, 32'd0);
    check_eq("async_rst.mem_addr", mem_addr, 32'd0);
    miss_req = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_beat.wen",     {30'd0, data_wen},   32'd0);
      check_eq("late_beat.tag_upd", {31'd0, tag_update}, 32'd0);
      check_eq("late_beat.done",    {31'd0, fill_done},  32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    tick();
    // Pointer was reset, so the next victim is way0 again.
    run_fill(32'h0000_0600, 2'b01, 1, 0, 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
